urand_norm: RTL and testbench

//   Upstream stage of ln for the Monte Carlo Hawkes sampler. Draws a uniform U in (0,1) from an

---
 rtl/urand_norm.sv | 103 ++++++++++
 tb/tb_urand_norm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/urand_norm.sv
// Uniform (0,1) sample source for ln: Galois LFSR draw, zero rejection, and range reduction
// of U to a Q1.8 mantissa m in [0.5,1) with shift count k so that U = m * 2^-k.
module urand_norm #(
    parameter int unsigned          LFSR_W = 16,
    parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0]    TAPS   = 16'hB400,
    parameter int unsigned          FRAC_W = 8,
    localparam int unsigned         K_W    = $clog2(FRAC_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic [FRAC_W:0]   x0,
    output logic [K_W-1:0]    k,
    output logic              start,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StDraw, StNorm, StEmit} state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [FRAC_W:0]     m_q, m_d;
    logic [FRAC_W:0]     x0_q, x0_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;

    logic [LFSR_W-1:0]   lfsr_step;
    logic [FRAC_W-1:0]   u;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign u         = lfsr_step[LFSR_W-1 -: FRAC_W];

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        m_d     = m_q;
        x0_d    = x0_q;
        k_d     = k_q;
        start_d = start_q;
        busy_d  = busy_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StDraw;
                    busy_d  = 1'b1;
                    k_d     = '0;
                end
            end
            StDraw: begin
                lfsr_d = lfsr_step;
                // A zero fraction would make ln(U) undefined, so keep drawing.
                if (u != '0) begin
                    m_d     = {1'b0, u};
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (m_q[FRAC_W-1]) begin
                    x0_d    = m_q;
                    start_d = 1'b1;
                    state_d = StEmit;
                end else begin
                    m_d = m_q << 1;
                    k_d = k_q + 1'b1;
                end
            end
            StEmit: begin
                start_d = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            m_q     <= '0;
            x0_q    <= '0;
            k_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            m_q     <= m_d;
            x0_q    <= x0_d;
            k_q     <= k_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign x0    = x0_q;
    assign k     = k_q;
    assign start = start_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_urand_norm.sv
// Bench for urand_norm: three instances with different seeds, checked against a sample-level
// model (LFSR sequence, zero rejection, leading-zero count) for values and latency.
module tb_urand_norm;

    logic       clk;
    logic       rst;
    logic       req_w   [3];
    logic [8:0] x0_w    [3];
    logic [2:0] k_w     [3];
    logic       start_w [3];
    logic       busy_w  [3];

    int vectors     = 0;
    int miscompares = 0;
    int starts   [3] = '{0, 0, 0};
    logic prev_start [3] = '{1'b0, 1'b0, 1'b0};

    logic [15:0] seeds  [3] = '{16'hACE1, 16'h0200, 16'h0002};
    logic [15:0] m_lfsr [3];

    urand_norm #(.LFSR_W(16), .SEED(16'hACE1), .TAPS(16'hB400), .FRAC_W(8)) dut_a (
        .clk(clk), .rst(rst), .req(req_w[0]), .x0(x0_w[0]), .k(k_w[0]),
        .start(start_w[0]), .busy(busy_w[0])
    );
    urand_norm #(.LFSR_W(16), .SEED(16'h0200), .TAPS(16'hB400), .FRAC_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(req_w[1]), .x0(x0_w[1]), .k(k_w[1]),
        .start(start_w[1]), .busy(busy_w[1])
    );
    urand_norm #(.LFSR_W(16), .SEED(16'h0002), .TAPS(16'hB400), .FRAC_W(8)) dut_c (
        .clk(clk), .rst(rst), .req(req_w[2]), .x0(x0_w[2]), .k(k_w[2]),
        .start(start_w[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start pulses: never two cycles in a row, mantissa always normalized.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (start_w[d]) begin
                starts[d]++;
                check("start_single", {31'd0, prev_start[d]}, 32'd0);
                check("x0_range", {31'd0, (x0_w[d] >= 9'h080) && (x0_w[d] <= 9'h0FF)}, 32'd1);
            end
            prev_start[d] = start_w[d];
        end
    end

    task automatic reload_models();
        for (int d = 0; d < 3; d++) m_lfsr[d] = seeds[d];
    endtask

    // Sample-level model: next nonzero fraction, then count leading zeros.
    task automatic model_draw(input int d, output logic [8:0] ex0, output int ek, output int ez);
        logic [7:0] u;
        ez = 0;
        do begin
            m_lfsr[d] = (m_lfsr[d] >> 1) ^ (m_lfsr[d][0] ? 16'hB400 : 16'h0000);
            u = m_lfsr[d][15:8];
            if (u == 8'h00) ez++;
        end while (u == 8'h00);
        ek = 0;
        while (!u[7]) begin
            u = u << 1;
            ek++;
        end
        ex0 = {1'b0, u};
    endtask

    // Caller is #1 after a rising edge. poke = loop index at which a stray req is raised.
    task automatic draw(input int d, input int poke, output logic [8:0] ox0, output int ok);
        logic [8:0] ex0;
        int ek, ez, n, s0;
        model_draw(d, ex0, ek, ez);
        s0 = starts[d];
        req_w[d] = 1'b1;
        @(posedge clk); #1;
        req_w[d] = 1'b0;
        check("busy_accept", {31'd0, busy_w[d]}, 32'd1);
        n = 0;
        while (!start_w[d] && n < 40) begin
            req_w[d] = (n == poke);
            @(posedge clk); #1;
            n++;
        end
        ox0 = x0_w[d];
        ok  = int'(k_w[d]);
        check("latency", n, ek + ez + 2);
        check("x0", {23'd0, x0_w[d]}, {23'd0, ex0});
        check("k", {29'd0, k_w[d]}, ek);
        check("busy_start", {31'd0, busy_w[d]}, 32'd1);
        req_w[d] = 1'b1;    // sampled in EMIT, must be ignored
        @(posedge clk); #1;
        req_w[d] = 1'b0;
        check("start_fall", {31'd0, start_w[d]}, 32'd0);
        check("busy_fall", {31'd0, busy_w[d]}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("x0_hold", {23'd0, x0_w[d]}, {23'd0, ex0});
        check("busy_idle", {31'd0, busy_w[d]}, 32'd0);
        check("one_start", starts[d] - s0, 32'd1);
    endtask

    initial begin
        logic [8:0] gx0;
        int gk, s1;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) req_w[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reload_models();
        for (int d = 0; d < 3; d++) begin
            check("rst_x0", {23'd0, x0_w[d]}, 32'd0);
            check("rst_k", {29'd0, k_w[d]}, 32'd0);
            check("rst_start", {31'd0, start_w[d]}, 32'd0);
            check("rst_busy", {31'd0, busy_w[d]}, 32'd0);
        end

        draw(0, -1, gx0, gk);
        check("t1_x0", {23'd0, gx0}, 32'h0E2);
        check("t1_k", gk, 32'd0);
        draw(0, -1, gx0, gk);
        check("t2_x0", {23'd0, gx0}, 32'h0E2);
        check("t2_k", gk, 32'd1);
        draw(1, 4, gx0, gk);
        check("t3_x0", {23'd0, gx0}, 32'h080);
        check("t3_k", gk, 32'd7);
        draw(2, 0, gx0, gk);
        check("t4_x0", {23'd0, gx0}, 32'h0B4);
        check("t4_k", gk, 32'd0);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            draw(0, int'($urandom_range(0, 10)), gx0, gk);
        end

        // Reset in the middle of normalization on the k=7 instance.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reload_models();
        s1 = starts[1];
        req_w[1] = 1'b1;
        @(posedge clk); #1;
        req_w[1] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reload_models();
        check("t6_start", {31'd0, start_w[1]}, 32'd0);
        check("t6_busy", {31'd0, busy_w[1]}, 32'd0);
        check("t6_x0", {23'd0, x0_w[1]}, 32'd0);
        check("t6_k", {29'd0, k_w[1]}, 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        check("t6_no_start", starts[1] - s1, 32'd0);
        draw(1, -1, gx0, gk);
        check("t6_replay_x0", {23'd0, gx0}, 32'h080);
        check("t6_replay_k", gk, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
